// File: rtl/dmem_mmio_bus.sv
// rtl/dmem_mmio_bus.sv - data RAM plus GPIO, timer and TX byte FIFO behind one load/store port
`timescale 1ns/1ps
module dmem_mmio_bus #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [31:0]   gpio_q, gpio_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   cmp_q, cmp_d;
    logic          flag_q, flag_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // RAM wins any overlap; the MMIO window is six consecutive words from MMIO_BASE
    logic        is_ram, mmio_hit;
    logic [29:0] off;
    assign is_ram   = ALUResult < 32'(RAM_WORDS * 4);
    assign off      = ALUResult[31:2] - MMIO_BASE[31:2];
    assign mmio_hit = !is_ram && (off < 30'd6);

    logic wr_gpio, wr_cnt, wr_cmp, wr_stat, wr_txd, wr_txs;
    assign wr_gpio = MemWrite && mmio_hit && (off[2:0] == 3'd0);
    assign wr_cnt  = MemWrite && mmio_hit && (off[2:0] == 3'd1);
    assign wr_cmp  = MemWrite && mmio_hit && (off[2:0] == 3'd2);
    assign wr_stat = MemWrite && mmio_hit && (off[2:0] == 3'd3);
    assign wr_txd  = MemWrite && mmio_hit && (off[2:0] == 3'd4);
    assign wr_txs  = MemWrite && mmio_hit && (off[2:0] == 3'd5);

    logic full, empty, pop, push, ovf_set;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop     = !empty && tx_ready;
    assign push    = wr_txd && (!full || pop);
    assign ovf_set = wr_txd && full && !pop;

    logic [31:0] tx_status;
    assign tx_status = {26'd0, ovf_q, 3'(cnt_q), empty, full};

    always_comb begin
        gpio_d   = wr_gpio ? WriteData : gpio_q;
        count_d  = wr_cnt ? WriteData : count_q + 32'd1;
        cmp_d    = wr_cmp ? WriteData : cmp_q;
        // a match on this edge beats a software clear
        flag_d   = (count_q == cmp_q) ? 1'b1 : ((wr_stat && WriteData[0]) ? 1'b0 : flag_q);
        ovf_d    = ovf_set ? 1'b1 : ((wr_txs && WriteData[5]) ? 1'b0 : ovf_q);
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q   <= '0;
            count_q  <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            flag_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            gpio_q   <= gpio_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // storage arrays are not reset; RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && is_ram) ram_q[ALUResult[RAW+1:2]] <= WriteData;
        if (!reset && push)               fifo_q[wr_ptr_q] <= WriteData[7:0];
    end

    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = ram_q[ALUResult[RAW+1:2]];
        end else if (mmio_hit) begin
            case (off[2:0])
                3'd0:    ReadData = gpio_q;
                3'd1:    ReadData = count_q;
                3'd2:    ReadData = cmp_q;
                3'd3:    ReadData = {31'd0, flag_q};
                3'd5:    ReadData = tx_status;
                default: ReadData = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = flag_q;
    assign tx_valid  = !empty;
    assign tx_data   = empty ? 8'h00 : fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_dmem_mmio_bus.sv
// tb/tb_dmem_mmio_bus.sv - directed and randomized check of dmem_mmio_bus against a queue-based model
`timescale 1ns/1ps
module tb_dmem_mmio_bus;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, MemWrite, tx_ready, timer_irq, tx_valid;
    logic [31:0] ALUResult, WriteData, ReadData, gpio_out;
    logic [7:0]  tx_data;

    dmem_mmio_bus #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .gpio_out(gpio_out),
        .timer_irq(timer_irq), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_ram [64];
    bit          m_ramv [64];
    logic [31:0] m_gpio, m_count, m_cmp;
    bit          m_flag, m_ovf;
    logic [7:0]  q [$];

    logic [31:0] last_rd, last_gpio;
    logic        last_irq, last_valid;
    logic [7:0]  last_txd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (a < 32'd256) return m_ram[a[7:2]];
        if (w == BASE)         return m_gpio;
        if (w == BASE + 4)     return m_count;
        if (w == BASE + 8)     return m_cmp;
        if (w == BASE + 12)    return {31'd0, m_flag};
        if (w == BASE + 20)    return {26'd0, m_ovf, 3'(q.size()), q.size() == 0, q.size() == DEPTH};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_gpio = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_flag = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic step(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy);
        logic [31:0] w;
        bit          pop, push, set, oset;
        reset = rst; MemWrite = we; ALUResult = a; WriteData = wd; tx_ready = rdy;
        @(negedge clk);
        last_rd = ReadData; last_irq = timer_irq; last_valid = tx_valid;
        last_txd = tx_data; last_gpio = gpio_out;
        if (!(a < 32'd256 && !m_ramv[a[7:2]])) chk("rdata", ReadData, mread(a));
        chk("irq", {31'd0, timer_irq}, {31'd0, m_flag});
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
        chk("tx_data", {24'd0, tx_data}, {24'd0, (q.size() != 0) ? q[0] : 8'h00});
        chk("gpio", gpio_out, m_gpio);
        if (rst) begin
            model_reset();
        end else begin
            w    = a & 32'hFFFF_FFFC;
            pop  = (q.size() != 0) && rdy;
            push = we && (w == BASE + 16);
            set  = (m_count == m_cmp);
            oset = 0;
            m_count = (we && w == BASE + 4) ? wd : m_count + 1;
            if (set) m_flag = 1;
            else if (we && w == BASE + 12 && wd[0]) m_flag = 0;
            if (we && w == BASE)     m_gpio = wd;
            if (we && w == BASE + 8) m_cmp  = wd;
            if (we && a < 32'd256) begin
                m_ram[a[7:2]] = wd; m_ramv[a[7:2]] = 1;
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(wd[7:0]);
                else oset = 1;
            end
            if (oset) m_ovf = 1;
            else if (we && w == BASE + 20 && wd[5]) m_ovf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy);
        step(1'b0, 1'b0, a, 32'd0, rdy);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        step(1'b0, 1'b1, a, wd, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  bytes [5];
        logic [31:0] a;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        for (int i = 0; i < 64; i++) m_ramv[i] = 0;
        reset = 1; MemWrite = 0; ALUResult = 0; WriteData = 0; tx_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset values, with a second reset applied while COUNT==5
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 4, 0);
            chk("cnt_run", last_rd, i);
        end
        step(1'b1, 1'b0, BASE + 4, 0, 0);
        chk("cnt_at_reset", last_rd, 5);
        rd(BASE + 4, 0);   chk("cnt_post_reset", last_rd, 0);
        rd(BASE + 8, 0);   chk("cmp_reset", last_rd, 32'hFFFF_FFFF);
        rd(BASE + 20, 0);  chk("txs_reset", last_rd, 32'h2);
        chk("txv_reset", {31'd0, last_valid}, 0);

        // RAM, out-of-range and GPIO
        wr(32'hFC, 32'hDEAD_BEEF, 0);
        rd(32'hFC, 0);     chk("ram63", last_rd, 32'hDEAD_BEEF);
        wr(32'h100, 32'h1234_5678, 0);
        wr(32'h2000, 32'hCAFE_F00D, 0);
        rd(32'h100, 0);    chk("oob_100", last_rd, 0);
        rd(32'h2000, 0);   chk("oob_2000", last_rd, 0);
        chk("gpio_untouched", last_gpio, 0);
        wr(BASE, 32'hA5A5_0001, 0);
        rd(BASE + 2, 0);   chk("gpio_rd", last_rd, 32'hA5A5_0001);

        // timer compare, irq latency and set-beats-clear
        wr(BASE + 8, 10, 0);
        wr(BASE + 4, 0, 0);
        for (int i = 0; i <= 10; i++) begin
            rd(BASE + 4, 0);
            chk("cnt_seq", last_rd, i);
        end
        chk("irq_not_yet", {31'd0, last_irq}, 0);
        rd(BASE + 12, 0);
        chk("irq_rise", {31'd0, last_irq}, 1);
        chk("status_set", last_rd, 1);
        wr(BASE + 12, 1, 0);
        rd(BASE + 12, 0);  chk("status_clr", last_rd, 0);
        wr(BASE + 4, 8, 0);
        rd(BASE + 4, 0);   chk("cnt8", last_rd, 8);
        rd(BASE + 4, 0);   chk("cnt9", last_rd, 9);
        wr(BASE + 12, 1, 0);
        rd(BASE + 12, 0);  chk("set_wins", last_rd, 1);
        wr(BASE + 12, 1, 0);
        rd(BASE + 12, 0);  chk("late_clr", last_rd, 0);

        // fill, overflow, drain in order
        for (int i = 0; i < 4; i++) wr(BASE + 16, {24'd0, bytes[i]}, 0);
        rd(BASE + 20, 0);  chk("txs_full", last_rd, 32'h11);
        wr(BASE + 16, 32'h55, 0);
        rd(BASE + 20, 0);  chk("txs_ovf", last_rd, 32'h31);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 20, 1);
            chk("drain_byte", {24'd0, last_txd}, {24'd0, bytes[i]});
        end
        rd(BASE + 20, 1);
        chk("drained_valid", {31'd0, last_valid}, 0);
        chk("drained_status", last_rd, 32'h22);
        wr(BASE + 20, 32'h20, 0);
        rd(BASE + 20, 0);  chk("ovf_clr", last_rd, 32'h2);

        // push into a full FIFO while it pops
        for (int i = 0; i < 4; i++) wr(BASE + 16, {24'd0, bytes[i]}, 0);
        wr(BASE + 16, 32'h66, 1);
        chk("pop_head", {24'd0, last_txd}, 32'h11);
        rd(BASE + 20, 0);  chk("full_pop_push", last_rd, 32'h11);
        bytes[0] = 8'h22; bytes[1] = 8'h33; bytes[2] = 8'h44; bytes[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 20, 1);
            chk("drain2", {24'd0, last_txd}, {24'd0, bytes[i]});
        end

        // reset mid-traffic flushes FIFO and keeps RAM
        for (int i = 0; i < 3; i++) wr(BASE + 16, 32'hA1 + i, 0);
        rd(BASE + 20, 1);
        step(1'b1, 1'b1, BASE + 16, 32'hB7, 1);
        rd(BASE + 20, 0);
        chk("rst_txs", last_rd, 32'h2);
        chk("rst_valid", {31'd0, last_valid}, 0);
        rd(32'hFC, 0);     chk("ram_kept", last_rd, 32'hDEAD_BEEF);

        // randomized traffic against the model
        for (int i = 0; i < 64; i++) wr(i * 4, $urandom, $urandom_range(0, 1));
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = $urandom_range(0, 255);
                9:       a = 32'h2000 + $urandom_range(0, 4095);
                default: a = BASE + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
            endcase
            if ((a & 32'hFFFF_FFFC) == BASE + 8 && $urandom_range(0, 1) == 1)
                step(1'b0, 1'b1, a, m_count + $urandom_range(1, 6), $urandom_range(0, 1));
            else
                step(1'b0, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
